// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : UART constants, receiver state encoding and parity helper,    |
// |            shared by receiver and transmitter (PARITY: UART_RX_PARITY_EN)|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam int BIT_IDX_W  = $clog2(DATA_W);

  // 2^32 * 16 * 115200 / 50e6, rounded down
  localparam logic [31:0] DEFAULT_BAUD_INC = 32'd158329674;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd5,
`endif
    WAIT_HIGH = 3'd4
  } rx_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_if : byte handshake and status bundle of the UART receiver       |
// |              (parity_err present with UART_RX_PARITY_EN)                 |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;
`ifdef UART_RX_PARITY_EN
  logic              parity_err;

  modport master (
    output data, data_valid, frame_err, overrun, busy, parity_err,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, frame_err, overrun, busy, parity_err,
    output data_ready
  );
`else
  modport master (
    output data, data_valid, frame_err, overrun, busy,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, frame_err, overrun, busy,
    output data_ready
  );
`endif

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_tick : phase-accumulator tick enable, tick = accumulator carry |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module uart_baud_tick #(
  parameter logic [31:0] BAUD_INC = uart_pkg::DEFAULT_BAUD_INC
) (
  input  logic clock50,
  input  logic reset_n,
  output logic tick
);

  logic [31:0] r_acc;
  logic        r_tick;
  logic [32:0] w_sum;

  // Extra top bit captures the carry; the low 32 bits wrap naturally
  assign w_sum = {1'b0, r_acc} + {1'b0, BAUD_INC};

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_sum[31:0];
      r_tick <= w_sum[32];
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx  : 16x oversampling 8N1 UART receiver with valid/ready output;   |
// |            optional even parity via UART_RX_PARITY_EN                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [31:0] BAUD_INC = DEFAULT_BAUD_INC
) (
  input  logic      clock50,
  input  logic      reset_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx;
  logic                 w_tick;
  logic                 w_mid;

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [OS_W-1:0]      r_os;
  logic [OS_W-1:0]      w_os_nxt;
  logic [BIT_IDX_W-1:0] r_bit;
  logic [BIT_IDX_W-1:0] w_bit_nxt;
  logic [DATA_W-1:0]    r_shift;
  logic [DATA_W-1:0]    w_shift_nxt;

  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_complete;
  logic                 w_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr;
  logic                 w_perr;
`endif

  // rx is asynchronous; idle-high reset value avoids a false start bit
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  uart_baud_tick #(
    .BAUD_INC (BAUD_INC)
  ) u_baud_tick (
    .clock50 (clock50),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign w_mid = w_tick && (r_os == OS_W'(MID_SAMPLE));

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_os    <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_os    <= w_os_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_complete  = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr      = 1'b0;
`endif

    if (w_tick && (r_state != IDLE) && (r_state != WAIT_HIGH)) begin
      w_os_nxt = r_os + OS_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_os_nxt    = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        // A start bit that has gone high again by mid-bit is a glitch
        if (w_mid) begin
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_mid) begin
          w_shift_nxt = {w_rx, r_shift[DATA_W-1:1]};
          if (r_bit == BIT_IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + BIT_IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_mid) begin
          w_perr      = (w_rx != even_parity(r_shift));
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_mid) begin
          if (w_rx) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Line held low (break): do not re-arm until it returns high
        if (w_rx) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_complete) begin
        // A same-cycle handshake frees the slot, so only an unconsumed byte is an overrun
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_ovr   <= r_valid && !bus.data_ready;
      end else if (r_valid && bus.data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_perr;
    end
  end

  assign bus.parity_err = r_perr;
`endif

  assign bus.data       = r_data;
  assign bus.data_valid = r_valid;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;
  assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_INC, default 158329674, the 32-bit phase increment per clock50 cycle giving 16x oversampling of 115200 baud at 50 MHz.
REQ-002 SHALL have port clock50  input  1  system clock; all logic in this single domain.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line: idle high, 8N1, LSB first.
REQ-005 SHALL have port data  output  8  last received byte.
REQ-006 SHALL have port data_valid  output  1  high while data holds an unconsumed byte.
REQ-007 SHALL have port data_ready  input  1  consumer accept; a byte transfers when data_valid and data_ready are both high.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a byte completes while data_valid is still high.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer, with both flops reset to 1, before any use.
REQ-012 SHALL derive a one-cycle tick enable from a 32-bit accumulator that adds BAUD_INC every clock; tick = carry out; no derived clocks.
REQ-013 SHALL use a 4-bit oversample counter, advanced on tick only, and a 3-bit bit index.
REQ-014 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH (plus PARITY when configured).
REQ-015 IDLE: when synced rx = 0, clear the oversample counter and go to START.
REQ-016 START: at oversample count 7 (mid-bit), go to DATA if rx = 0; otherwise return to IDLE as a glitch, with no outputs pulsed.
REQ-017 DATA: sample at every count-7 point, shifting into bit index 0..7 LSB first; after bit 7, go to STOP.
REQ-018 STOP at mid-bit, rx = 1: load data, set data_valid on the next clock, and go to IDLE.
REQ-019 STOP at mid-bit, rx = 0: pulse frame_err, leave data and data_valid unchanged, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH: remain there until synced rx = 1 (break handling), then go to IDLE.
REQ-021 data_valid SHALL clear on the clock after a data_ready handshake; data SHALL stay stable while data_valid is high, except on overrun.
REQ-022 On a completion with data_valid already high: overwrite data, keep data_valid high, and pulse overrun.
REQ-023 On a handshake in the same cycle as a completion: data_valid stays high with the new byte and no overrun pulses.
REQ-024 The accumulator SHALL wrap modulo 2^32; the oversample counter SHALL wrap 15 -> 0.

Reset
REQ-025 While reset_n is low: state = IDLE, accumulator and counters = 0, synchronizer = 1, data = 8'h00, and data_valid, frame_err, overrun, busy = 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, the block resumes by waiting in IDLE for the next falling edge.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined: a PARITY state sits between DATA and STOP, samples an even-parity bit, and adds output parity_err (1 bit, one-cycle pulse on mismatch); the byte is still delivered when the stop bit is good.
REQ-028 Without UART_RX_PARITY_EN: no PARITY state and no parity_err port; the frame is strictly 8N1.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum, DATA_W = 8, OVERSAMPLE = 16, MID_SAMPLE = 7 and the default BAUD_INC; the same package is shared with the transmitter.
REQ-030 Tick generation SHALL live in sub-module uart_baud_tick (parameter BAUD_INC, ports clock50, reset_n, tick).

Verification
REQ-031 Send 8'h55 at 115200 with data_ready held high -> data = 8'h55, data_valid high for one cycle, no error pulses.
REQ-032 Send 8'hA3 with data_ready low, then 8'h3C -> overrun pulses once, data = 8'h3C, data_valid stays high until data_ready.
REQ-033 A 2 us low glitch on idle rx -> returns to IDLE, data_valid stays 0, busy returns to 0 within 1 bit time.
REQ-034 Frame 8'h0F with stop bit forced 0, then rx held low for 3 bit times -> one frame_err pulse, busy stays high until rx rises, data unchanged.
REQ-035 reset_n pulsed low during bit 4 of 8'hFF, then 8'h81 sent -> only 8'h81 is delivered.
REQ-036 With UART_RX_PARITY_EN, send 8'h07 carrying parity bit 0 -> parity_err pulses once and data = 8'h07 is delivered.
